// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer for a register-file ALU datapath: a DEPTH-entry
// instruction FIFO feeding a four-state READ/EXEC/WB controller.
module alu_seq_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [2:0] instr_dst,
    input  logic [2:0] instr_srca,
    input  logic [2:0] instr_srcb,
    input  logic       instr_nowb,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic [2:0] rd_addr_a,
    output logic [2:0] rd_addr_b,
    output logic [2:0] alu_op,
    output logic       wr,
    output logic [2:0] wr_addr,
    output logic       flag_z,
    output logic       flag_c,
    output logic       busy,
    output logic       done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] dst;
        logic [2:0] srca;
        logic [2:0] srcb;
        logic       nowb;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    instr_t          fifo_mem [DEPTH];
    instr_t          instr_in;
    instr_t          instr_reg;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    state_t          state;
    state_t          state_next;

    assign instr_in = '{op: instr_op, dst: instr_dst, srca: instr_srca,
                        srcb: instr_srcb, nowb: instr_nowb};

    // Ready depends only on the registered count, so a same-cycle pop never
    // opens a slot early.
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign instr_ready = ~full;
    assign push        = instr_valid & instr_ready;
    assign pop         = (state == IDLE) & ~empty;

    // NOTE: storage array has no reset; validity is tracked by count/pointers,
    // which keeps the array a plain RAM without a reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= instr_in;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            instr_reg <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            state <= state_next;
            if (pop) begin
                instr_reg <= fifo_mem[rd_ptr];
            end
            if (state == EXEC) begin
                flag_z <= alu_zero;
                flag_c <= alu_carry;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned (which would infer a latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!empty) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset of the state drops wr/done without waiting for a clock.
    always_comb begin
        rd_addr_a = '0;
        rd_addr_b = '0;
        alu_op    = '0;
        wr_addr   = '0;
        wr        = 1'b0;
        done      = 1'b0;
        if (state != IDLE) begin
            rd_addr_a = instr_reg.srca;
            rd_addr_b = instr_reg.srcb;
            alu_op    = instr_reg.op;
            wr_addr   = instr_reg.dst;
        end
        if (state == WB) begin
            wr   = ~instr_reg.nowb;
            done = 1'b1;
        end
    end

    assign busy = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl (DEPTH = 4): latency,
// compare-only instructions, full-queue backpressure, pointer wrap and reset.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_dst;
    logic [2:0] instr_srca;
    logic [2:0] instr_srcb;
    logic       instr_nowb;
    logic       alu_zero;
    logic       alu_carry;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [2:0] alu_op;
    logic       wr;
    logic [2:0] wr_addr;
    logic       flag_z;
    logic       flag_c;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int done_count = 0;
    logic [5:0] done_log [64];

    alu_seq_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_dst(instr_dst),
        .instr_srca(instr_srca), .instr_srcb(instr_srcb),
        .instr_nowb(instr_nowb),
        .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .alu_op(alu_op),
        .wr(wr), .wr_addr(wr_addr), .flag_z(flag_z), .flag_c(flag_c),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Completion log: {alu_op, wr_addr} of every done pulse, in order.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (done_count < 64) done_log[done_count] = {alu_op, wr_addr};
            done_count = done_count + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_instr(input logic [2:0] op, input logic [2:0] dst,
                              input logic [2:0] sa, input logic [2:0] sb, input logic nowb);
        instr_op    = op;
        instr_dst   = dst;
        instr_srca  = sa;
        instr_srcb  = sb;
        instr_nowb  = nowb;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && done_count < target; i++) step(1);
        check(tag, done_count, target);
    endtask

    initial begin
        int base;
        logic [5:0] id;

        reset = 1'b1;
        instr_valid = 1'b0;
        instr_op = '0; instr_dst = '0; instr_srca = '0; instr_srcb = '0;
        instr_nowb = 1'b0;
        alu_zero = 1'b0;
        alu_carry = 1'b0;
        step(3);

        // Reset state
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wr", wr, 0);
        check("rst_done", done, 0);
        check("rst_flags", {flag_z, flag_c}, 0);
        check("rst_addrs", {rd_addr_a, rd_addr_b, alu_op, wr_addr}, 0);
        reset = 1'b0;
        step(1);

        // Single instruction latency: op=3 dst=5 srca=1 srcb=2
        push_instr(3'd3, 3'd5, 3'd1, 3'd2, 1'b0);
        check("lat_idle_busy", busy, 1);
        check("lat_idle_addr", rd_addr_a, 0);
        step(1);
        check("lat_read_addrs", {rd_addr_a, rd_addr_b, alu_op}, {3'd1, 3'd2, 3'd3});
        check("lat_read_wr", {wr, done}, 0);
        step(1);
        alu_zero = 1'b0;
        alu_carry = 1'b1;
        check("lat_exec_wr", {wr, done}, 0);
        step(1);
        check("lat_wb_wr_done", {wr, done}, 2'b11);
        check("lat_wb_wr_addr", wr_addr, 5);
        check("lat_wb_flags", {flag_z, flag_c}, 2'b01);
        alu_carry = 1'b0;
        step(1);
        check("lat_after_wb", {wr, done, busy}, 0);
        check("lat_idle_op", alu_op, 0);

        // Compare-only instruction with zero flag
        push_instr(3'd6, 3'd7, 3'd4, 3'd4, 1'b1);
        step(2);
        alu_zero = 1'b1;
        step(1);
        check("nowb_wb", {wr, done}, 2'b01);
        check("nowb_flags", {flag_z, flag_c}, 2'b10);
        alu_zero = 1'b0;
        step(1);
        check("nowb_flag_hold", {flag_z, done}, 2'b10);

        // Five back-to-back pushes: queue fills after the fifth
        base = done_count;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_ready_%0d", i), instr_ready, 1);
            push_instr(3'(i), 3'(i + 1), 3'd1, 3'd2, 1'b0);
        end
        check("fill_full_ready", instr_ready, 0);
        check("fill_full_busy", busy, 1);
        step(1);
        check("fill_ready_after_pop", instr_ready, 1);
        wait_done("fill_drain", base + 5, 40);
        for (int i = 0; i < 5; i++) begin
            id = {3'(i), 3'(i + 1)};
            check($sformatf("fill_order_%0d", i), done_log[base + i], id);
        end
        step(1);

        // Steady state at count 2: push coincides with every pop, wraps twice
        base = done_count;
        for (int n = 0; n < 10; n++) begin
            id = 6'(n);
            if (n >= 3) begin
                step(n == 3 ? 2 : 3);
                check($sformatf("wrap_ready_%0d", n), instr_ready, 1);
                check($sformatf("wrap_done_%0d", n), done_count - base, n - 2);
            end
            push_instr(id[5:3], id[2:0], 3'd1, 3'd1, 1'b0);
        end
        wait_done("wrap_drain", base + 10, 60);
        for (int n = 0; n < 10; n++) begin
            check($sformatf("wrap_order_%0d", n), done_log[base + n], 6'(n));
        end
        step(1);

        // Reset during EXEC with two entries queued
        alu_zero = 1'b1;
        alu_carry = 1'b1;
        push_instr(3'd1, 3'd1, 3'd1, 3'd1, 1'b0);
        step(4);
        check("pre_rst_flags", {flag_z, flag_c}, 2'b11);
        push_instr(3'd2, 3'd2, 3'd3, 3'd3, 1'b0);
        push_instr(3'd4, 3'd3, 3'd3, 3'd3, 1'b0);
        push_instr(3'd5, 3'd4, 3'd3, 3'd3, 1'b0);
        check("pre_rst_exec", {busy, rd_addr_a, alu_op}, {1'b1, 3'd3, 3'd2});
        base = done_count;
        #1 reset = 1'b1;
        #1;
        check("rst_exec_wr_busy", {wr, busy, done}, 0);
        check("rst_exec_flags", {flag_z, flag_c}, 0);
        check("rst_exec_ready", instr_ready, 1);
        alu_zero = 1'b0;
        alu_carry = 1'b0;
        step(1);
        reset = 1'b0;
        step(20);
        check("rst_exec_no_done", done_count, base);
        check("rst_exec_idle", busy, 0);

        // Reset during WB drops wr without a clock edge
        base = done_count;
        push_instr(3'd2, 3'd6, 3'd1, 3'd1, 1'b0);
        step(3);
        check("rst_wb_pre", {wr, wr_addr}, {1'b1, 3'd6});
        #1 reset = 1'b1;
        #1;
        check("rst_wb_wr", {wr, done}, 0);
        step(1);
        reset = 1'b0;
        step(5);
        check("rst_wb_no_done", done_count, base);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr_valid  input  1  requester offers an instruction.
REQ-005 SHALL have port instr_ready  output  1  queue can accept; high exactly when queue not full.
REQ-006 SHALL have port instr_op  input  3  ALU operation code.
REQ-007 SHALL have port instr_dst  input  3  destination register index.
REQ-008 SHALL have port instr_srca  input  3  register index for ALU operand A.
REQ-009 SHALL have port instr_srcb  input  3  register index for ALU operand B.
REQ-010 SHALL have port instr_nowb  input  1  1 = compare-only, no write-back.
REQ-011 SHALL have port alu_zero  input  1  ALU zero flag.
REQ-012 SHALL have port alu_carry  input  1  ALU carry flag.
REQ-013 SHALL have port rd_addr_a  output  3  register-file read address A.
REQ-014 SHALL have port rd_addr_b  output  3  register-file read address B.
REQ-015 SHALL have port alu_op  output  3  operation code to ALU.
REQ-016 SHALL have port wr  output  1  register-file write enable.
REQ-017 SHALL have port wr_addr  output  3  register-file write address.
REQ-018 SHALL have port flag_z  output  1  captured zero flag.
REQ-019 SHALL have port flag_c  output  1  captured carry flag.
REQ-020 SHALL have port busy  output  1  high when FSM not IDLE or queue not empty.
REQ-021 SHALL have port done  output  1  one-cycle pulse per completed instruction.

Function
REQ-022 SHALL push {op,dst,srca,srcb,nowb} into a FIFO of DEPTH entries on each edge where instr_valid and instr_ready are both high.
REQ-023 SHALL hold instr_ready low when full, even if a pop occurs in the same cycle.
REQ-024 SHALL keep entry count unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-025 SHALL implement FSM states IDLE, READ, EXEC, WB, each lasting exactly one cycle except IDLE.
REQ-026 SHALL, in IDLE with queue non-empty, pop the head into an instruction register and go to READ.
REQ-027 SHALL go READ -> EXEC -> WB unconditionally, and WB -> IDLE.
REQ-028 SHALL drive rd_addr_a/rd_addr_b/alu_op/wr_addr from the instruction register in READ, EXEC, WB; drive all to 0 in IDLE.
REQ-029 SHALL capture alu_zero into flag_z and alu_carry into flag_c at the edge leaving EXEC; flags hold otherwise.
REQ-030 SHALL assert wr only in WB and only when nowb = 0; wr is 0 in all other states.
REQ-031 SHALL assert done for exactly the WB cycle, regardless of nowb.
REQ-032 SHALL give latency: instruction pushed at edge E0 into empty idle block -> READ after E1, wr/done high in cycle after E3, register written at E4.
REQ-033 SHALL sustain throughput of one instruction per 4 cycles with a non-empty queue.
REQ-034 SHALL accept pushes in every FSM state while not full.
REQ-035 SHALL treat instructions with dst equal to srca or srcb normally; no hazard stalls required (operands read before write).

Reset
REQ-036 SHALL, while reset high, force FSM to IDLE, FIFO empty, pointers 0, flag_z = flag_c = 0, wr = done = busy = 0, all address/op outputs 0, instr_ready = 1.
REQ-037 SHALL discard any in-flight instruction on reset mid-operation; wr drops immediately (asynchronously).

Verification
REQ-038 Single instruction op=3, dst=5, srca=1, srcb=2, nowb=0 -> rd_addr_a=1, rd_addr_b=2, alu_op=3 from READ; wr=1, wr_addr=5, done=1 exactly one cycle, 4th cycle after push.
REQ-039 Push 5 instructions back-to-back with DEPTH=4 while FSM stalled -> instr_ready drops after 4th accepted entry (one popped first allows 5th); all 5 complete in order, done count = 5.
REQ-040 nowb=1 instruction with alu_zero=1 during EXEC -> wr stays 0, done pulses, flag_z=1 after EXEC.
REQ-041 Reset asserted during EXEC with 2 queued entries -> wr, busy, flags 0 immediately; after release, no further done pulses.
REQ-042 Simultaneous push and pop at count=2 -> count stays 2, ordering preserved through pointer wrap (≥ 2*DEPTH instructions).
